// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter.
//   sw_state_t        : mode FSM encoding (IDLE, RUN, PAUSE, LAP)
//   COUNT_W           : width of the seconds count / displayed value
//   DEFAULT_MAX_COUNT : terminal count used when the parent does not override it
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  localparam int COUNT_W           = 6;
  localparam int DEFAULT_MAX_COUNT = 59;

endpackage

// File: rtl/edge_detect.sv
// One-flop rising-edge detector for an already-synchronised button level.
//   clk   : system clock
//   reset : asynchronous, active-high reset (history flop cleared to 0)
//   in    : synchronised button level
//   rise  : high for the single cycle where in=1 and the previous sample was 0
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_q;
  logic in_d;

  always_comb begin
    in_d = in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_d;
    end
  end

  // Because in_q resets to 0, a button held through reset release yields one
  // edge on the first clock after release.
  assign rise = in & ~in_q;

endmodule

// File: rtl/stopwatch_counter.sv
// 0..MAX_COUNT seconds stopwatch feeding the two-digit seven-segment decoder.
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   start_stop : synchronised level; rising edge toggles run/pause
//   lap        : synchronised level; rising edge freezes/releases displayed value
//   clear      : synchronised level; rising edge zeroes the count when not running
//   out        : displayed value, always 0..MAX_COUNT
//   running    : registered, high in RUN and LAP
//   wrap       : one-cycle pulse while the count first shows 0 after rollover
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV   = 50_000_000,
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_stop,
  input  logic               lap,
  input  logic               clear,
  output logic [COUNT_W-1:0] out,
  output logic               running,
  output logic               wrap
);

  if (MAX_COUNT > 63 || MAX_COUNT < 1) begin : g_bad_max_count
    $error("stopwatch_counter: MAX_COUNT must be within 1..63");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("stopwatch_counter: CLK_DIV must be at least 2");
  end

  localparam int                   PRESC_W    = $clog2(CLK_DIV);
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [COUNT_W-1:0]   MAX_C      = COUNT_W'(MAX_COUNT);

  logic ss_rise, lap_rise, clear_rise;

  edge_detect u_ss_edge    (.clk(clk), .reset(reset), .in(start_stop), .rise(ss_rise));
  edge_detect u_lap_edge   (.clk(clk), .reset(reset), .in(lap),        .rise(lap_rise));
  edge_detect u_clear_edge (.clk(clk), .reset(reset), .in(clear),      .rise(clear_rise));

  sw_state_t           state_q,   state_d;
  logic [COUNT_W-1:0]  count_q,   count_d;
  logic [COUNT_W-1:0]  lap_val_q, lap_val_d;
  logic [PRESC_W-1:0]  presc_q,   presc_d;
  logic                wrap_q,    wrap_d;
  logic                running_q, running_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    lap_val_d = lap_val_q;
    presc_d   = presc_q;
    wrap_d    = 1'b0;

    // Timebase runs off the current state, so the cycle that leaves RUN/LAP
    // still advances the prescaler and a resume continues the partial second.
    if (state_q == RUN || state_q == LAP) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        wrap_d  = (count_q == MAX_C);
        count_d = (count_q == MAX_C) ? '0 : count_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // Edges ignored in a state do not take part in arbitration; among the
    // meaningful ones clear beats start_stop beats lap, losers are dropped.
    unique case (state_q)
      IDLE: begin
        if (clear_rise) begin
          count_d = '0;
          presc_d = '0;
        end else if (ss_rise) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ss_rise) begin
          state_d = PAUSE;
        end else if (lap_rise) begin
          state_d   = LAP;
          lap_val_d = count_d;  // includes a same-cycle increment
        end
      end
      LAP: begin
        if (ss_rise) begin
          state_d = PAUSE;
        end else if (lap_rise) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (clear_rise) begin
          state_d = IDLE;
          count_d = '0;
          presc_d = '0;
        end else if (ss_rise) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN) || (state_d == LAP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      lap_val_q <= '0;
      presc_q   <= '0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      lap_val_q <= lap_val_d;
      presc_q   <= presc_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
    end
  end

  assign out     = (state_q == LAP) ? lap_val_q : count_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [5:0] out;
  logic       running;
  logic       wrap;

  stopwatch_counter #(.CLK_DIV(4), .MAX_COUNT(59)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .out        (out),
    .running    (running),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [5:0] out;
    logic       running;
    logic       wrap;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Expected response for the negedge following posedge number c.
  task automatic expect_at(input int c, input int o, input bit r, input bit w, input string n);
    exp_t e;
    int   i;
    e.at      = c;
    e.out     = 6'(o);
    e.running = r;
    e.wrap    = w;
    e.name    = n;
    i = 0;
    while (i < sb.size() && sb[i].at <= c) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.at != cyc || out !== mon_e.out || running !== mon_e.running || wrap !== mon_e.wrap) begin
        errors++;
        $display("FAIL %s cyc=%0d got out=%0d running=%0b wrap=%0b expected (cyc %0d) out=%0d running=%0b wrap=%0b",
                 mon_e.name, cyc, out, running, wrap, mon_e.at, mon_e.out, mon_e.running, mon_e.wrap);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  int b;
  int guard;

  initial begin
    reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_at(cyc, 0, 0, 0, "reset_state");
    reset = 1'b0;

    // Start: edge registered at posedge b; count n appears at b+4n.
    b = cyc + 1;
    start_stop = 1'b1;
    expect_at(b,       0, 1, 0, "run_start");
    expect_at(b + 3,   0, 1, 0, "pre_first_step");
    expect_at(b + 4,   1, 1, 0, "first_step");
    expect_at(b + 8,   2, 1, 0, "second_step");
    expect_at(b + 236, 59, 1, 0, "at_max");
    expect_at(b + 239, 59, 1, 0, "max_hold");
    expect_at(b + 240, 0, 1, 1, "wrap_pulse");
    expect_at(b + 241, 0, 1, 0, "wrap_one_cycle");
    expect_at(b + 244, 1, 1, 0, "after_wrap");
    wait_until(b);
    start_stop = 1'b0;

    // Lap freeze at 12, release shows live 17.
    expect_at(b + 288, 12, 1, 0, "pre_lap");
    expect_at(b + 289, 12, 1, 0, "lap_freeze");
    expect_at(b + 300, 12, 1, 0, "lap_hold_mid");
    expect_at(b + 308, 12, 1, 0, "lap_hold_end");
    expect_at(b + 309, 17, 1, 0, "lap_release");
    expect_at(b + 312, 18, 1, 0, "live_after_lap");
    wait_until(b + 288); lap = 1'b1;
    wait_until(b + 289); lap = 1'b0;
    wait_until(b + 308); lap = 1'b1;
    wait_until(b + 309); lap = 1'b0;

    // Pause two cycles into a prescaler period, resume completes the period.
    expect_at(b + 314, 18, 0, 0, "paused");
    expect_at(b + 364, 18, 0, 0, "pause_hold");
    expect_at(b + 365, 18, 1, 0, "resumed");
    expect_at(b + 366, 18, 1, 0, "resume_partial");
    expect_at(b + 367, 19, 1, 0, "resume_step");
    expect_at(b + 371, 20, 1, 0, "resume_next");
    wait_until(b + 313); start_stop = 1'b1;
    wait_until(b + 314); start_stop = 1'b0;
    wait_until(b + 364); start_stop = 1'b1;
    wait_until(b + 365); start_stop = 1'b0;

    // Clear from PAUSE at 33, then clear ignored in RUN.
    expect_at(b + 424, 33, 0, 0, "pause_33");
    expect_at(b + 431, 0, 0, 0, "clear_idle");
    expect_at(b + 440, 0, 0, 0, "idle_hold");
    expect_at(b + 442, 0, 1, 0, "restart");
    expect_at(b + 447, 1, 1, 0, "clear_in_run");
    wait_until(b + 423); start_stop = 1'b1;
    wait_until(b + 424); start_stop = 1'b0;
    wait_until(b + 430); clear = 1'b1;
    wait_until(b + 431); clear = 1'b0;
    wait_until(b + 441); start_stop = 1'b1;
    wait_until(b + 442); start_stop = 1'b0;
    wait_until(b + 446); clear = 1'b1;
    wait_until(b + 447); clear = 1'b0;

    // Lap on the increment cycle captures the incremented value.
    expect_at(b + 450, 2, 1, 0, "lap_same_inc");
    expect_at(b + 454, 2, 1, 0, "lap_frozen");
    expect_at(b + 456, 3, 1, 0, "lap_off");
    expect_at(b + 458, 4, 0, 0, "pause_on_inc");
    wait_until(b + 449); lap = 1'b1;
    wait_until(b + 450); lap = 1'b0;
    wait_until(b + 455); lap = 1'b1;
    wait_until(b + 456); lap = 1'b0;
    wait_until(b + 457); start_stop = 1'b1;
    wait_until(b + 458); start_stop = 1'b0;

    // start_stop and clear together in PAUSE: clear wins.
    expect_at(b + 461, 0, 0, 0, "clear_beats_ss");
    expect_at(b + 470, 0, 0, 0, "stays_idle");
    wait_until(b + 460); start_stop = 1'b1; clear = 1'b1;
    wait_until(b + 461); start_stop = 1'b0; clear = 1'b0;

    // Async reset between edges mid-run; button held across release.
    expect_at(b + 472, 0, 1, 0, "run_again");
    expect_at(b + 480, 2, 1, 0, "before_reset");
    expect_at(b + 481, 0, 0, 0, "async_reset");
    expect_at(b + 482, 0, 0, 0, "reset_held");
    expect_at(b + 484, 0, 1, 0, "held_edge");
    expect_at(b + 488, 1, 1, 0, "held_count");
    expect_at(b + 490, 1, 1, 0, "held_no_retoggle");
    wait_until(b + 471); start_stop = 1'b1;
    wait_until(b + 472); start_stop = 1'b0;
    wait_until(b + 481);
    #2;
    reset = 1'b1;
    start_stop = 1'b1;
    wait_until(b + 483); reset = 1'b0;
    wait_until(b + 491); start_stop = 1'b0;

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
